// File: rtl/loader_pkg.sv
// Shared types and sizing for the serial program loader.
package loader_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_ZERO_WORDS = 256;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned IDX_W          = $clog2(LEN_ZERO_WORDS);
    localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CSUM,
        DONE
    } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
// full_o is a look-ahead: three bytes are held, so the next load completes the word.
module byte_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              flush_i,
    output logic [WORD_W-1:0] word_o,
    output logic              full_o
);

    logic [BCNT_W-1:0] cnt_q;
    logic [WORD_W-1:0] word_q;

    // New bytes enter at the top so the first byte ends up in [7:0].
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (flush_i) begin
            cnt_q  <= '0;
        end else if (load_i) begin
            word_q <= {byte_i, word_q[WORD_W-1:BYTE_W]};
            cnt_q  <= cnt_q + BCNT_W'(1);
        end
    end

    assign word_o = word_q;
    assign full_o = (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Serial loader: length byte, little-endian words, optional XOR checksum, into word memory.
// Trailing checksum byte and sticky error flag exist only with PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_data,
    output logic              mem_wen,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    loader_state_t     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BYTE_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              byte_ready_q, byte_ready_d;
    logic              mem_wen_q, mem_wen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
    logic              err_q, err_d;
`endif

    logic              xfer_c;
    logic              asm_full_c;
    logic [WORD_W-1:0] asm_word;

    assign xfer_c = byte_valid && byte_ready_q;

    byte_assembler u_asm (
        .clk     (clk),
        .clr_n   (clr_n),
        .load_i  (xfer_c && (state_q == DATA)),
        .byte_i  (byte_data),
        .flush_i (start && (state_q == IDLE)),
        .word_o  (asm_word),
        .full_o  (asm_full_c)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            byte_ready_q <= 1'b0;
            mem_wen_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            byte_ready_q <= byte_ready_d;
            mem_wen_q    <= mem_wen_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
            err_q        <= err_d;
`endif
        end
    end

    // Next state; outputs are registered by decoding the upcoming state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        addr_d  = addr_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LEN;
                    idx_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            LEN: begin
                if (xfer_c) begin
                    len_d   = byte_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ byte_data;
`endif
                    state_d = DATA;
                end
            end
            DATA: begin
                if (xfer_c) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data;
`endif
                    if (asm_full_c) begin
                        state_d = WRITE;
                        addr_d  = BASE_ADDR + ADDR_W'(idx_q);
                    end
                end
            end
            WRITE: begin
                // len 0 wraps to 0xFF here, i.e. 256 words.
                if (idx_q == IDX_W'(len_q - BYTE_W'(1))) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
`endif
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = DATA;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (xfer_c) begin
                    if (byte_data != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        byte_ready_d = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
        mem_wen_d    = (state_d == WRITE);
        busy_d       = (state_d != IDLE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        done_d       = (state_d == DONE) && !err_d;
`else
        done_d       = (state_d == DONE);
`endif
    end

    assign byte_ready = byte_ready_q;
    assign mem_addr   = addr_q;
    assign mem_data   = asm_word;
    assign mem_wen    = mem_wen_q;
    assign busy       = busy_q;
    assign cpu_hold   = busy_q;
    assign done       = done_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign error      = err_q;
`else
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: random streams, stalls, wrap, reset abort, start-while-busy.
module tb_program_loader;

    localparam int unsigned ADDR_W = 8;
    localparam logic [7:0]  BASE   = 8'hFE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              clr_n = 1'b1;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              mem_wen;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wen    (mem_wen),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    bit          exp_done_q[$];
    bit          exp_err_q[$];
    logic [31:0] words[$];
    bit          mon_prev_busy = 1'b0;
    bit          mon_saw_done  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  64'(mem_addr), 64'(0));
        check({tag, "_data"},  64'(mem_data), 64'(0));
        check({tag, "_wen"},   64'(mem_wen), 64'(0));
        check({tag, "_ready"}, 64'(byte_ready), 64'(0));
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_hold"},  64'(cpu_hold), 64'(0));
        check({tag, "_done"},  64'(done), 64'(0));
        check({tag, "_error"}, 64'(error), 64'(0));
    endtask

    // Monitor: every write and every load completion is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!clr_n) begin
                mon_prev_busy = 1'b0;
                mon_saw_done  = 1'b0;
            end else begin
                if (mem_wen) begin
                    check("wr_ready_low", 64'(byte_ready), 64'(0));
                    check("wr_hold", 64'(cpu_hold), 64'(1));
                    if (exp_addr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write required", mem_addr, mem_data);
                    end else begin
                        check("wr_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
                        check("wr_data", 64'(mem_data), 64'(exp_data_q.pop_front()));
                    end
                end
                if (done) mon_saw_done = 1'b1;
                if (mon_prev_busy && !busy) begin
                    if (exp_done_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_end: load ended with no load outstanding");
                    end else begin
                        check("done_pulse", 64'(mon_saw_done), 64'(exp_done_q.pop_front()));
                        check("error_flag", 64'(error), 64'(exp_err_q.pop_front()));
                    end
                    mon_saw_done = 1'b0;
                end
                mon_prev_busy = busy;
            end
        end
    end

    // Offers one byte, optionally after random idle cycles; returns at the negedge after capture.
    task automatic send_byte(input logic [7:0] b, input bit stall);
        int t;
        if (stall) begin
            while ($urandom_range(1, 0) == 0) @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!byte_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_timeout: byte_ready stayed 0 for byte 0x%0h", b);
        end else begin
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic begin_load();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold_after_start", 64'(cpu_hold), 64'(1));
        check("busy_after_start", 64'(busy), 64'(1));
        check("error_cleared", 64'(error), 64'(0));
    endtask

    // Reference model: words go to (BASE+i) mod 256; checksum is XOR of length and data bytes.
    task automatic run_load(input int len, input bit bad, input bit stall, input bit start_busy);
        int         nw;
        int         t;
        logic [7:0] x;
        logic [7:0] b;
        nw = (len == 0) ? 256 : len;
        while (words.size() < nw) words.push_back($urandom);
        exp_done_q.push_back(!(bad && CSUM_EN));
        exp_err_q.push_back(bad && CSUM_EN);
        begin_load();
        x = 8'(len);
        send_byte(8'(len), stall);
        for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = words[w][8*k +: 8];
                x = x ^ b;
                if (k == 3) begin
                    exp_addr_q.push_back(8'((int'(BASE) + w) % 256));
                    exp_data_q.push_back(words[w]);
                end
                if (start_busy && w == 0 && k == 1) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                send_byte(b, stall);
            end
        end
        if (CSUM_EN) send_byte(bad ? (x ^ 8'h01) : x, stall);
        words.delete();
        t = 0;
        while (busy && t < 32) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL load_end_timeout: busy still 1 after final byte");
        end
        check("hold_released", 64'(cpu_hold), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 clr_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        #3 clr_n = 1'b1;

        // Basic fixed stream
        words.push_back(32'h12345678);
        words.push_back(32'hDEADBEEF);
        run_load(2, 1'b0, 1'b0, 1'b0);

        // Same stream with corrupted checksum, then a load that must clear the error
        words.push_back(32'h12345678);
        words.push_back(32'hDEADBEEF);
        run_load(2, 1'b1, 1'b0, 1'b0);
        run_load(3, 1'b0, 1'b0, 1'b0);

        // Random stalls, and start pulsed mid-load
        run_load(5, 1'b0, 1'b1, 1'b0);
        run_load(4, 1'b0, 1'b1, 1'b1);

        // 256-word load wrapping the address
        run_load(0, 1'b0, 1'b1, 1'b0);

        // Reset after two bytes of the second word
        words.push_back($urandom);
        words.push_back($urandom);
        begin_load();
        send_byte(8'd2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                exp_addr_q.push_back(BASE);
                exp_data_q.push_back(words[0]);
            end
            send_byte(words[0][8*k +: 8], 1'b0);
        end
        send_byte(words[1][7:0], 1'b0);
        send_byte(words[1][15:8], 1'b0);
        #2 clr_n = 1'b0;
        #1 check_all_zero("midreset");
        check("word0_written", 64'(exp_addr_q.size()), 64'(0));
        words.delete();
        @(negedge clk);
        #3 clr_n = 1'b1;
        run_load(1, 1'b0, 1'b0, 1'b0);

        // Random short loads with random checksum corruption
        for (int i = 0; i < 4; i++) begin
            run_load(int'($urandom_range(8, 1)), bit'($urandom_range(1, 0)), 1'b1, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("writes_drained", 64'(exp_addr_q.size()), 64'(0));
        check("loads_drained", 64'(exp_done_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Serial program/data loader that writes a byte stream into the processor's word-addressed data memory. It receives a length byte, then little-endian 32-bit words, then (optionally) a checksum byte. Each complete word is written to consecutive memory addresses. It holds the processor in clear for the whole load, so memory is initialised before the single-cycle core runs. It drives the same addr/data_in/wen port the core uses and is muxed onto it while `cpu_hold` is high.

## Interface
- `ADDR_W`, 8: memory word-address width; must be ≥ 8.
- `BASE_ADDR`, 0: word address of the first loaded word.

- `clk`  in  1  system clock (processor clock domain).
- `clr_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  incoming stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle; a transfer occurs when `byte_valid && byte_ready`.
- `mem_addr`  out  ADDR_W  word address to memory.
- `mem_data`  out  32  word to memory.
- `mem_wen`  out  1  memory write enable, one-cycle pulse per word.
- `cpu_hold`  out  1  drives processor `clr` and the memory port mux.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  sticky checksum-fail flag; cleared by an accepted `start`.

## Operation
- FSM states: IDLE, LEN, DATA, WRITE, CSUM, DONE.
- IDLE → LEN on `start`. `error` clears on the same edge.
- LEN: accept 1 byte as N. N = 0 means 256 words. → DATA.
- DATA: accept bytes into the assembler, least-significant byte first. The 4th byte → WRITE.
- WRITE (1 cycle): `mem_wen`=1, `mem_addr` = (BASE_ADDR + idx) mod 2^ADDR_W, `mem_data` = assembled word.
  - If idx = N−1 → CSUM (or DONE with the macro off).
  - Otherwise idx++ and → DATA.
- CSUM: accept 1 byte. Compare it against the running XOR of the length byte and all data bytes. Mismatch sets `error`. → DONE.
- DONE (1 cycle): `done` = !error. → IDLE.
- `byte_ready` = 1 only in LEN, DATA and CSUM.
- `cpu_hold` = `busy`.
- `start` is ignored while busy.
- Words already written are not rolled back on checksum failure.
- Address wrap: BASE_ADDR + idx overflowing 2^ADDR_W wraps to 0 silently.

## Timing
- Reset values (asynchronous, immediate): state IDLE; `byte_ready`, `mem_wen`, `cpu_hold`, `busy`, `done`, `error` = 0; `mem_addr`, `mem_data` = 0; idx = 0; XOR accumulator = 0.
- Reset asserted mid-load aborts at once. `mem_wen` drops asynchronously, and a partial word is discarded.
- The byte is captured on the rising edge where `byte_valid && byte_ready`.
- `byte_valid` may stall arbitrarily. `byte_ready` never depends combinationally on `byte_valid`.
- Latency: `mem_wen` is asserted the cycle after the edge capturing a word's 4th byte.
- Throughput: at most 1 word per 5 cycles.
- `cpu_hold` rises the cycle after `start` and falls the cycle after DONE.
- `done` aligns with DONE.
- `mem_addr`/`mem_data` are registered and stable throughout WRITE.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined:
  - CSUM state and XOR accumulator are present.
  - The stream carries a trailing checksum byte.
  - `error` is functional.
- Not defined:
  - No CSUM state; the last WRITE goes directly to DONE.
  - The stream ends after the last data byte.
  - `error` is tied to 0.

## Structure
- `loader_pkg` holds:
  - the state enum typedef `loader_state_t`;
  - `WORD_W` = 32;
  - `BYTES_PER_WORD` = 4;
  - `LEN_ZERO_WORDS` = 256.
- Sub-module `byte_assembler`:
  - 2-bit byte counter and 32-bit shift/insert register;
  - inputs `clk`, `clr_n`, `load`, `byte`, `flush`;
  - outputs `word`, `full`.
- Top-level FSM, idx counter, checksum and memory outputs live in `program_loader`.

## Test plan
- Basic load: N=2, bytes 78 56 34 12 EF BE AD DE + correct csum → writes 0x12345678 @0 and 0xDEADBEEF @1, `done` pulse, `error`=0, `cpu_hold` low after.
- Bad checksum: same stream with csum XOR 0x01 → both words written, `error`=1, no `done`; next `start` clears `error`.
- Backpressure/stall: `byte_valid` toggled randomly 50% → identical writes. No byte is lost or duplicated, and `byte_ready`=0 during every WRITE cycle.
- Wrap and length 0: BASE_ADDR=0xFE, N=0 (256 words) → 256 `mem_wen` pulses. Addresses run 0xFE, 0xFF, 0x00 … 0xFD.
- Reset mid-word: `clr_n` low after 2 bytes of word 1 → outputs zero immediately. After release, a fresh N=1 load writes only its word @BASE_ADDR.
- Start while busy: `start` pulsed in DATA → ignored, and the load completes normally with the original N.
